// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared register-file geometry and dump-engine state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int NREGS  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } dump_state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_dump_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dump_if
//  Purpose  : Control, regfile read port and beat stream of the dump engine.
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_dump_if
    import regfile_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = REG_DW
) ();

    logic          start;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    // Engine side
    modport master (
        input  start, first, last, rdata, out_ready,
        output raddr, out_valid, out_addr, out_data, out_last, busy, done
    );

    // Controller / regfile / sink side
    modport slave (
        output start, first, last, rdata, out_ready,
        input  raddr, out_valid, out_addr, out_data, out_last, busy, done
    );

endinterface : regfile_dump_if
`default_nettype wire

// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dump
//  Purpose  : Walks a register address range and streams {addr, data} beats.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_dump
    import regfile_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = REG_DW
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_dump_if.master bus
);

    dump_state_t   state_q;
    logic [AW-1:0] cur_q;
    logic [AW-1:0] end_q;
    logic          out_valid_q;
    logic [AW-1:0] out_addr_q;
    logic [DW-1:0] out_data_q;
    logic          out_last_q;
    logic          done_q;
    logic          load;

    // One output register: refill whenever it is empty or being drained.
    assign load = (state_q == SCAN) && (!out_valid_q || bus.out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            end_q       <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.first <= bus.last) begin
                            cur_q   <= bus.first;
                            end_q   <= bus.last;
                            state_q <= SCAN;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (load) begin
                        out_valid_q <= 1'b1;
                        out_addr_q  <= cur_q;
                        out_data_q  <= bus.rdata;
                        out_last_q  <= (cur_q == end_q);
                        // Stop at end rather than incrementing, so end=31 never wraps.
                        if (cur_q == end_q) begin
                            state_q <= DRAIN;
                        end else begin
                            cur_q   <= cur_q + 1'b1;
                        end
                    end else if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.raddr     = cur_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);

endmodule : regfile_dump
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_dump
//  Purpose  : Randomized self-checking bench for regfile_dump with a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem [32];
    int          n_tests;
    int          n_fail;

    regfile_dump_if #(.AW(5), .DW(32)) bus ();

    regfile_dump #(.AW(5), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural regfile read port: address 0 is hardwired to zero.
    assign bus.rdata = (bus.raddr == 5'd0) ? 32'd0 : mem[bus.raddr];

    function automatic logic [31:0] reg_val(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mem[a];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // rmode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int rmode,
                           input int abort_at, input bit inj_start, input bit inj_wr);
        logic [4:0] q [$];
        int  k;
        bit  exp_done;
        bit  nd;
        bit  fin;
        bit  wrote;
        q = {};
        for (int a = int'(f); a <= int'(l); a++) q.push_back(5'(a));
        @(negedge clk);
        bus.start = 1'b1;
        bus.first = f;
        bus.last  = l;
        exp_done  = (q.size() == 0);
        k = 0; fin = 1'b0; wrote = 1'b0;
        while (!fin) begin
            @(negedge clk);
            k++;
            bus.start = 1'b0;
            if (inj_start && k == 3) begin
                bus.start = 1'b1;
                bus.first = 5'd20;
                bus.last  = 5'd25;
            end
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (((k - 1) % 4) == 0) || (((k - 1) % 4) == 3);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            chk("done",  64'(bus.done),      64'(exp_done));
            chk("busy",  64'(bus.busy),      64'(q.size() > 0));
            chk("valid", 64'(bus.out_valid), 64'((k >= 2) && (q.size() > 0)));
            if (bus.out_valid && q.size() > 0) begin
                chk("addr", 64'(bus.out_addr), 64'(q[0]));
                chk("data", 64'(bus.out_data), 64'(reg_val(q[0])));
                chk("last", 64'(bus.out_last), 64'(q.size() == 1));
                if (inj_wr && q[0] == 5'd20)
                    chk("wr_visible", 64'(bus.out_data), 64'h0000_0000_DEAD_BEEF);
            end
            if (abort_at >= 0 && bus.out_valid && int'(bus.out_addr) == abort_at) begin
                rst_n = 1'b0;
                bus.out_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk("abort_valid", 64'(bus.out_valid), 64'd0);
                chk("abort_busy",  64'(bus.busy),      64'd0);
                chk("abort_done",  64'(bus.done),      64'd0);
                @(negedge clk);
                chk("abort_done2", 64'(bus.done),      64'd0);
                chk("abort_valid2", 64'(bus.out_valid), 64'd0);
                return;
            end
            // Regfile write to an address the scan has not reached yet.
            if (inj_wr && !wrote && bus.out_valid && bus.out_addr == 5'd5) begin
                mem[20] = 32'hDEAD_BEEF;
                wrote   = 1'b1;
            end
            if (exp_done) fin = 1'b1;
            nd = 1'b0;
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                nd = (q.size() == 1);
                void'(q.pop_front());
            end
            exp_done = nd;
            if (!fin && k > 300) begin
                chk("timeout", 64'd1, 64'd0);
                fin = 1'b1;
            end
        end
        if (rmode == 0) chk("done_latency", 64'(k), 64'(int'(l) - int'(f) + 3 > 1 ? ((f <= l) ? int'(l) - int'(f) + 3 : 1) : 1));
        @(negedge clk);
        chk("done_pulse", 64'(bus.done), 64'd0);
        chk("idle_busy",  64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [4:0] rf;
        logic [4:0] rl;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.start = 1'b0;
        bus.first = '0;
        bus.last  = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_addr",  64'(bus.out_addr),  64'd0);
        chk("rst_data",  64'(bus.out_data),  64'd0);
        chk("rst_last",  64'(bus.out_last),  64'd0);
        chk("rst_done",  64'(bus.done),      64'd0);
        chk("rst_busy",  64'(bus.busy),      64'd0);
        chk("rst_raddr", 64'(bus.raddr),     64'd0);
        rst_n = 1'b1;

        do_dump(5'd0,  5'd31, 0, -1, 1'b0, 1'b0);
        do_dump(5'd3,  5'd6,  1, -1, 1'b0, 1'b0);
        do_dump(5'd7,  5'd7,  0, -1, 1'b0, 1'b0);
        do_dump(5'd9,  5'd2,  0, -1, 1'b0, 1'b0);
        do_dump(5'd10, 5'd14, 0, -1, 1'b1, 1'b0);
        do_dump(5'd0,  5'd31, 0, 10, 1'b0, 1'b0);
        do_dump(5'd0,  5'd31, 0, -1, 1'b0, 1'b0);
        do_dump(5'd0,  5'd31, 0, -1, 1'b0, 1'b1);

        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 32; i++) mem[i] = $urandom;
            rf = 5'($urandom_range(0, 31));
            rl = 5'($urandom_range(0, 31));
            do_dump(rf, rl, 2, -1, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_dump
`default_nettype wire
